// File: rtl/draw_sprite.sv
// Sprite overlay stage: draws a ROM-backed image onto the VGA pixel stream with
// colour-key transparency, per-axis mirroring and a configurable ROM read latency.
module draw_sprite #(
  parameter int unsigned IMG_W_LOG2 = 5,
  parameter int unsigned IMG_H_LOG2 = 5,
  parameter int unsigned ROM_LAT    = 1,
  parameter bit          KEY_EN     = 1'b1,
  parameter logic [11:0] KEY_COLOR  = 12'hF0F
) (
  input  logic                           pclk,
  input  logic                           rst,
  input  logic [10:0]                    hcount_in,
  input  logic [10:0]                    vcount_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           hblnk_in,
  input  logic                           vblnk_in,
  input  logic [11:0]                    rgb_in,
  input  logic                           visible,
  input  logic [10:0]                    xpos,
  input  logic [10:0]                    ypos,
  input  logic                           mirror_x,
  input  logic                           mirror_y,
  input  logic [11:0]                    rgb_pixel,
  output logic [10:0]                    hcount_out,
  output logic [10:0]                    vcount_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           hblnk_out,
  output logic                           vblnk_out,
  output logic [11:0]                    rgb_out,
  output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] pixel_addr
);

  localparam int unsigned L     = ROM_LAT + 2;
  localparam int unsigned AW    = IMG_W_LOG2 + IMG_H_LOG2;
  localparam logic [11:0] IMG_W = 12'd1 << IMG_W_LOG2;
  localparam logic [11:0] IMG_H = 12'd1 << IMG_H_LOG2;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } timing_t;

  logic        r_vblnk_prev;
  logic        r_visible_s;
  logic [10:0] r_xpos_s;
  logic [10:0] r_ypos_s;
  logic        r_mirror_x_s;
  logic        r_mirror_y_s;

  timing_t     r_tpipe    [L];
  logic [L-2:0] r_hit_pipe;
  logic [11:0] r_rgb_pipe [L-1];
  logic [AW-1:0] r_addr;
  logic [11:0] r_rgb_out;

  logic                  w_latch;
  logic                  w_hit;
  logic [11:0]           w_x_end;
  logic [11:0]           w_y_end;
  logic [IMG_W_LOG2-1:0] w_col;
  logic [IMG_H_LOG2-1:0] w_row;
  logic                  w_keyed;
  logic                  w_show;

  // 12-bit end coordinates so a sprite near 2047 clips instead of wrapping.
  always_comb begin
    w_latch = vblnk_in && !r_vblnk_prev;
    w_x_end = {1'b0, r_xpos_s} + IMG_W;
    w_y_end = {1'b0, r_ypos_s} + IMG_H;
    w_hit   = r_visible_s && !hblnk_in && !vblnk_in
              && (hcount_in >= r_xpos_s) && ({1'b0, hcount_in} < w_x_end)
              && (vcount_in >= r_ypos_s) && ({1'b0, vcount_in} < w_y_end);
    w_col   = IMG_W_LOG2'(hcount_in - r_xpos_s) ^ {IMG_W_LOG2{r_mirror_x_s}};
    w_row   = IMG_H_LOG2'(vcount_in - r_ypos_s) ^ {IMG_H_LOG2{r_mirror_y_s}};
    w_keyed = KEY_EN && (rgb_pixel == KEY_COLOR);
    w_show  = r_hit_pipe[L-2] && !w_keyed;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_visible_s  <= 1'b0;
      r_xpos_s     <= '0;
      r_ypos_s     <= '0;
      r_mirror_x_s <= 1'b0;
      r_mirror_y_s <= 1'b0;
      r_addr       <= '0;
      r_hit_pipe   <= '0;
      r_rgb_out    <= '0;
      for (int unsigned i = 0; i < L; i++)     r_tpipe[i]    <= '0;
      for (int unsigned i = 0; i < L - 1; i++) r_rgb_pipe[i] <= '0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (w_latch) begin
        r_visible_s  <= visible;
        r_xpos_s     <= xpos;
        r_ypos_s     <= ypos;
        r_mirror_x_s <= mirror_x;
        r_mirror_y_s <= mirror_y;
      end
      r_addr     <= w_hit ? {w_row, w_col} : '0;
      r_tpipe[0] <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      for (int unsigned i = 1; i < L; i++) r_tpipe[i] <= r_tpipe[i-1];
      // hit/background run L-1 stages so they meet rgb_pixel at the final edge
      r_hit_pipe    <= {r_hit_pipe[L-3:0], w_hit};
      r_rgb_pipe[0] <= rgb_in;
      for (int unsigned i = 1; i < L - 1; i++) r_rgb_pipe[i] <= r_rgb_pipe[i-1];
      r_rgb_out <= w_show ? rgb_pixel : r_rgb_pipe[L-2];
    end
  end

  assign hcount_out = r_tpipe[L-1].hc;
  assign vcount_out = r_tpipe[L-1].vc;
  assign hsync_out  = r_tpipe[L-1].hs;
  assign vsync_out  = r_tpipe[L-1].vs;
  assign hblnk_out  = r_tpipe[L-1].hb;
  assign vblnk_out  = r_tpipe[L-1].vb;
  assign rgb_out    = r_rgb_out;
  assign pixel_addr = r_addr;

endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: three configurations (default, no colour key, small
// sprite with ROM latency 3) share one stimulus and are checked against a model.
module tb_draw_sprite;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } out_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, xpos, ypos;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        visible, mirror_x, mirror_y;
  logic [11:0] rgb_in;

  logic [10:0] hco [3];
  logic [10:0] vco [3];
  logic        hso [3], vso [3], hbo [3], vbo [3];
  logic [11:0] rgbo [3];
  logic [11:0] pix [3];
  logic [9:0]  addr0, addr1;
  logic [6:0]  addr2;
  logic [11:0] rom2_a, rom2_b;

  out_t        d_out  [3];
  logic [31:0] d_addr [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  function automatic logic [11:0] rom_data(int a);
    return (a == 5) ? 12'hF0F : 12'(a);
  endfunction

  // ROM models with the matching read latency
  always @(posedge pclk) pix[0] <= rom_data(int'(addr0));
  always @(posedge pclk) pix[1] <= rom_data(int'(addr1));
  always @(posedge pclk) begin
    rom2_a <= rom_data(int'(addr2));
    rom2_b <= rom2_a;
    pix[2] <= rom2_b;
  end

  draw_sprite u_def (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .visible(visible), .xpos(xpos), .ypos(ypos),
    .mirror_x(mirror_x), .mirror_y(mirror_y), .rgb_pixel(pix[0]),
    .hcount_out(hco[0]), .vcount_out(vco[0]), .hsync_out(hso[0]), .vsync_out(vso[0]),
    .hblnk_out(hbo[0]), .vblnk_out(vbo[0]), .rgb_out(rgbo[0]), .pixel_addr(addr0)
  );

  draw_sprite #(.KEY_EN(1'b0)) u_nokey (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .visible(visible), .xpos(xpos), .ypos(ypos),
    .mirror_x(mirror_x), .mirror_y(mirror_y), .rgb_pixel(pix[1]),
    .hcount_out(hco[1]), .vcount_out(vco[1]), .hsync_out(hso[1]), .vsync_out(vso[1]),
    .hblnk_out(hbo[1]), .vblnk_out(vbo[1]), .rgb_out(rgbo[1]), .pixel_addr(addr1)
  );

  draw_sprite #(.IMG_W_LOG2(4), .IMG_H_LOG2(3), .ROM_LAT(3)) u_clip (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .visible(visible), .xpos(xpos), .ypos(ypos),
    .mirror_x(mirror_x), .mirror_y(mirror_y), .rgb_pixel(pix[2]),
    .hcount_out(hco[2]), .vcount_out(vco[2]), .hsync_out(hso[2]), .vsync_out(vso[2]),
    .hblnk_out(hbo[2]), .vblnk_out(vbo[2]), .rgb_out(rgbo[2]), .pixel_addr(addr2)
  );

  always_comb begin
    for (int c = 0; c < 3; c++)
      d_out[c] = {hco[c], vco[c], hso[c], vso[c], hbo[c], vbo[c], rgbo[c]};
    d_addr[0] = 32'(addr0);
    d_addr[1] = 32'(addr1);
    d_addr[2] = 32'(addr2);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   cw [3]   = '{5, 5, 4};
  int   chh [3]  = '{5, 5, 3};
  int   clat [3] = '{1, 1, 3};
  bit   ckey [3] = '{1'b1, 1'b0, 1'b1};

  bit   m_vis [3], m_mx [3], m_my [3], m_vprev [3];
  int   m_x [3], m_y [3];
  out_t m_pipe [3][6];
  out_t exp_out [3];
  int   exp_addr [3];
  bit   started = 1'b0;

  always @(posedge pclk) begin
    int   w, h, hc, vc, col, row, a, depth;
    bit   hit;
    logic [11:0] p, colour;
    out_t nw;
    started = 1'b1;
    for (int c = 0; c < 3; c++) begin
      depth = clat[c] + 1;
      if (rst) begin
        m_vis[c] = 0; m_mx[c] = 0; m_my[c] = 0; m_vprev[c] = 0;
        m_x[c] = 0; m_y[c] = 0;
        for (int i = 0; i < 6; i++) m_pipe[c][i] = '0;
        exp_out[c] = '0;
        exp_addr[c] = 0;
      end else begin
        w  = 1 << cw[c];
        h  = 1 << chh[c];
        hc = int'(hcount_in);
        vc = int'(vcount_in);
        hit = m_vis[c] && !hblnk_in && !vblnk_in &&
              hc >= m_x[c] && hc < m_x[c] + w && vc >= m_y[c] && vc < m_y[c] + h;
        a = 0;
        if (hit) begin
          col = hc - m_x[c];
          row = vc - m_y[c];
          if (m_mx[c]) col = w - 1 - col;
          if (m_my[c]) row = h - 1 - row;
          a = row * w + col;
        end
        p = rom_data(a);
        colour = (hit && !(ckey[c] && p == 12'hF0F)) ? p : rgb_in;
        nw = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, colour};
        exp_addr[c] = a;
        exp_out[c]  = m_pipe[c][0];
        for (int i = 0; i < depth - 1; i++) m_pipe[c][i] = m_pipe[c][i+1];
        m_pipe[c][depth-1] = nw;
        if (vblnk_in && !m_vprev[c]) begin
          m_vis[c] = visible; m_x[c] = int'(xpos); m_y[c] = int'(ypos);
          m_mx[c] = mirror_x; m_my[c] = mirror_y;
        end
        m_vprev[c] = vblnk_in;
      end
    end
  end

  always @(negedge pclk) begin
    if (started) begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("dut%0d_outputs", c), 64'(d_out[c]), 64'(exp_out[c]));
        check($sformatf("dut%0d_pixel_addr", c), 64'(d_addr[c]), 64'(exp_addr[c]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic line(int vc, int h0, int h1, bit hb = 1'b0);
    for (int hh = h0; hh <= h1; hh++) begin
      hcount_in = 11'(hh); vcount_in = 11'(vc);
      rgb_in = 12'(hh * 7 + vc * 13);
      hsync_in = (hh % 5 == 0); vsync_in = 1'b0;
      hblnk_in = hb; vblnk_in = 1'b0;
      step();
    end
  endtask

  task automatic vpulse(int n);
    vblnk_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1;
    repeat (n) step();
    vblnk_in = 1'b0; vsync_in = 1'b0;
  endtask

  // hand-computed pins: pixel_addr one edge later, rgb_out/hcount_out L edges later
  task automatic probe(int c, int hc, int vc, logic [11:0] rgb, int ea, logic [11:0] er);
    hcount_in = 11'(hc); vcount_in = 11'(vc); rgb_in = rgb;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    step();
    check($sformatf("pin%0d_addr_%0d_%0d", c, hc, vc), 64'(d_addr[c]), 64'(ea));
    repeat (clat[c] + 1) step();
    check($sformatf("pin%0d_rgb_%0d_%0d", c, hc, vc), 64'(d_out[c].rgb), 64'(er));
    check($sformatf("pin%0d_hcount_%0d_%0d", c, hc, vc), 64'(d_out[c].hc), 64'(hc));
  endtask

  initial begin
    rst = 1'b1; hcount_in = '0; vcount_in = '0; rgb_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
    visible = 1'b1; xpos = 11'd100; ypos = 11'd50; mirror_x = 1'b0; mirror_y = 1'b0;
    repeat (3) step();
    check("reset_rgb_out", 64'(d_out[0].rgb), 64'd0);
    check("reset_pixel_addr", 64'(d_addr[0]), 64'd0);

    // vblnk high out of reset latches on the first cycle
    rst = 1'b0;
    repeat (2) step();
    vblnk_in = 1'b0;
    line(49, 96, 136);
    line(50, 96, 136);
    line(55, 98, 110, 1'b1);
    line(81, 126, 134);
    probe(0, 100, 50, 12'hABC, 0, 12'h000);
    probe(0, 131, 81, 12'h777, 1023, 12'h3FF);
    probe(0, 132, 81, 12'h456, 0, 12'h456);
    probe(0, 105, 50, 12'h123, 5, 12'h123);
    probe(1, 105, 50, 12'h123, 5, 12'hF0F);

    // move mid-frame: takes effect only at the next vblnk rising edge
    xpos = 11'd200;
    line(60, 96, 236);
    probe(0, 100, 60, 12'h321, 320, 12'h140);
    probe(0, 200, 60, 12'h321, 0, 12'h321);
    vblnk_in = 1'b1; hblnk_in = 1'b1;
    step();
    xpos = 11'd300;
    repeat (2) step();
    vblnk_in = 1'b0;
    line(60, 96, 236);
    probe(0, 200, 60, 12'h321, 320, 12'h140);
    probe(0, 100, 60, 12'h321, 0, 12'h321);

    // mirroring
    xpos = 11'd100; mirror_x = 1'b1; mirror_y = 1'b1;
    vpulse(2);
    line(50, 96, 136);
    line(81, 96, 136);
    probe(0, 100, 50, 12'h111, 1023, 12'h3FF);
    probe(0, 131, 50, 12'h111, 992, 12'h3E0);

    // clipping at the right edge of the counter range
    xpos = 11'd2040; mirror_x = 1'b0; mirror_y = 1'b0;
    vpulse(2);
    line(52, 2036, 2047);
    line(52, 0, 10);
    probe(2, 2040, 52, 12'h555, 32, 12'h020);
    probe(2, 2047, 52, 12'h555, 39, 12'h027);
    probe(2, 0, 52, 12'h555, 0, 12'h555);
    probe(2, 7, 52, 12'h555, 0, 12'h555);
    probe(0, 2047, 52, 12'h555, 71, 12'h047);

    // reset during a hit
    xpos = 11'd100;
    vpulse(2);
    hcount_in = 11'd110; vcount_in = 11'd55; rgb_in = 12'hAAA; hblnk_in = 1'b0;
    step();
    check("pre_reset_addr", 64'(d_addr[0]), 64'd170);
    rst = 1'b1;
    step();
    check("midreset_outputs", 64'(d_out[0]), 64'd0);
    check("midreset_addr", 64'(d_addr[0]), 64'd0);
    check("midreset_addr_clip", 64'(d_addr[2]), 64'd0);
    rst = 1'b0;
    line(55, 100, 140);
    probe(0, 110, 55, 12'hAAA, 0, 12'hAAA);
    vpulse(2);
    probe(0, 110, 55, 12'hAAA, 170, 12'h0AA);
    line(56, 95, 140);

    repeat (6) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_sprite.md
# draw_sprite

Parametrised, frame-synchronous sprite overlay stage for the VGA timing pipeline. It draws a 2^IMG_W_LOG2 x 2^IMG_H_LOG2 image read from an external synchronous ROM onto the incoming pixel stream, with these additions:
- optional colour-key transparency;
- per-axis mirroring;
- a configurable ROM read latency.

Position, mirror and enable settings are latched once per frame, at the start of vertical blanking, so a sprite never tears mid-frame.

## Interface
Parameters:
- IMG_W_LOG2, 5, log2 of sprite width in pixels (1..8)
- IMG_H_LOG2, 5, log2 of sprite height in pixels (1..8)
- ROM_LAT, 1, pclk cycles from pixel_addr change to matching rgb_pixel (1..4)
- KEY_EN, 1, enables colour-key transparency
- KEY_COLOR, 12'hF0F, transparent colour

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- hcount_in, vcount_in  in  11  pixel counters
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  timing signals
- rgb_in  in  12  background colour
- visible  in  1  sprite enable (shadowed)
- xpos, ypos  in  11  top-left sprite corner (shadowed)
- mirror_x, mirror_y  in  1  horizontal/vertical flip (shadowed)
- rgb_pixel  in  12  ROM data
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing signals
- rgb_out  out  12  composited colour
- pixel_addr  out  IMG_W_LOG2+IMG_H_LOG2  ROM address, {row, column}

## Operation
- **Shadow latch.** visible, xpos, ypos, mirror_x and mirror_y are copied into shadow registers on any cycle where vblnk_in=1 and vblnk_prev=0.
  - vblnk_prev is a register of vblnk_in, reset to 0. A vblnk_in held high out of reset therefore latches on the first cycle.
  - Inputs are sampled as presented in that same cycle.
  - All drawing uses only the shadow values.
- **Hit test (stage 0).** Compares use 12-bit sums, so there is no wrap.
  - Hit = shadow visible, AND hblnk_in=0, AND vblnk_in=0.
  - AND hcount_in ≥ x_s, AND hcount_in < x_s + 2^IMG_W_LOG2.
  - AND vcount_in ≥ y_s, AND vcount_in < y_s + 2^IMG_H_LOG2.
  - A sprite extending past the active area is clipped by the counters, never wrapped.
- **Address.**
  - col = low IMG_W_LOG2 bits of (hcount_in − x_s), bit-inverted when mirror_x.
  - row = low IMG_H_LOG2 bits of (vcount_in − y_s), bit-inverted when mirror_y.
  - pixel_addr = {row, col} on a hit, 0 otherwise.
- **Compositing.** On a hit, rgb_out = rgb_pixel, unless KEY_EN=1 and rgb_pixel == KEY_COLOR, in which case rgb_out = the aligned rgb_in. On a miss, rgb_out = the aligned rgb_in.
- **Alignment.** The hit flag and rgb_in are carried in a delay line so they meet the rgb_pixel returned for the same pixel.

## Timing
- **Total latency.** L = ROM_LAT + 2 edges from input to every output (default 3).
  - Edge 1: pixel_addr registered.
  - ROM data valid after edge 1 + ROM_LAT.
  - Edge L: rgb_out registered.
- **Output alignment.** All timing outputs are delayed by exactly L, so rgb_out stays aligned to hcount_out/vcount_out.
- **Reset.** rst=1 at an edge forces the following to 0 on the next cycle, mid-frame included:
  - all outputs;
  - all delay-line stages;
  - vblnk_prev;
  - all shadow registers (visible_s=0, so nothing is drawn until the first latch).
- **Pipeline restart after reset.** Valid outputs resume L cycles after rst deasserts; zeros are emitted during refill.
- **Position changes.** Changes to xpos/ypos outside the latch cycle have no visible effect until the next vblnk rising edge.

## Test plan
- **Basic draw.** Defaults; latch xpos=100, ypos=50, visible=1; ROM returns addr as colour.
  - At hcount=100, vcount=50: pixel_addr=0 one cycle later, and rgb_out=12'h000 three cycles later with hcount_out=100.
  - At hcount=131, vcount=81: addr=1023.
  - At hcount=132: rgb_out=rgb_in.
- **Mirror.** mirror_x=1, mirror_y=1, same position.
  - At hcount=100, vcount=50: pixel_addr=1023.
  - At hcount=131, vcount=50: pixel_addr=992.
- **Transparency.** ROM returns 12'hF0F at addr 5, rgb_in=12'h123: rgb_out=12'h123 at that pixel. With KEY_EN=0: rgb_out=12'hF0F.
- **Frame-synchronous move.** Change xpos to 200 mid-frame: the remainder of the frame still draws at 100; the next frame draws at 200.
- **Clipping and parameters.** Use xpos=2040 with IMG_W_LOG2=4, IMG_H_LOG2=3, ROM_LAT=3.
  - Hits occur only for hcount 2040..2047, with no hits at hcount 0..7.
  - Latency is 5, and pixel_addr is 7 bits wide.
- **Reset mid-frame.** Assert rst during a hit: all outputs are 0 the next cycle. After release, no sprite is drawn until a vblnk rising edge latches visible=1.
